mem_rmw_bridge: RTL
===================

Name: mem_rmw_bridge

Overview:
- Sits between the multi-cycle CPU datapath and the unified instruction/data memory.
- The memory exposes only a word-wide, combinational-read, clocked-write port (MemRead/MemWrite, word index = Address[9:2]). This block adds byte and halfword loads with sign/zero extension, and byte/halfword stores via a two-cycle read-modify-write FSM.
- Stalls the CPU with cpu_ready during the RMW sequence.

Parameters:
- ADDR_W, 32, CPU/memory address width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_addr  input  32  byte address from CPU.
- cpu_wdata  input  32  store data; sub-word data is right-justified.
- cpu_read  input  1  load request.
- cpu_write  input  1  store request.
- cpu_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- cpu_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- cpu_rdata  output  32  extracted and extended load data.
- cpu_ready  output  1  access completes this cycle.
- mem_addr  output  32  word-aligned address to memory ({cpu_addr[31:2],2'b00}).
- mem_wdata  output  32  word written to memory.
- mem_read  output  1  memory MemRead.
- mem_write  output  1  memory MemWrite.
- mem_rdata  input  32  memory Mem_data, combinational.
- fault  output  1  sticky misalignment flag (see Optional Feature).

Behaviour:
- Byte lanes are little-endian: byte offset k = cpu_addr[1:0] occupies bits [8k+7:8k]. The halfword at offset 0 is bits 15:0; at offset 2, bits 31:16.
- FSM states: IDLE, RMW_WR, FAULT.
- Reset, asynchronous: state=IDLE, merge buffer=0, fault=0. mem_write is 0 during and after reset until a request arrives.
- Loads, IDLE, cpu_read=1:
  - mem_read=1 and cpu_ready=1 in the same cycle (zero added latency).
  - cpu_rdata = extracted lane, sign-extended from bit 7/15 or zero-extended per cpu_unsigned.
  - Word loads pass mem_rdata through unchanged.
- Word stores, IDLE, cpu_write=1, size word:
  - mem_write=1, mem_wdata=cpu_wdata, cpu_ready=1, single cycle. State stays IDLE.
- Sub-word stores:
  - Cycle 1 (IDLE): mem_read=1, mem_write=0, cpu_ready=0. On the clock edge, register merged = mem_rdata with the target lane replaced by cpu_wdata[7:0] or [15:0]. Go to RMW_WR.
  - Cycle 2 (RMW_WR): mem_write=1, mem_wdata=merged, mem_read=0, cpu_ready=1. Return to IDLE.
  - Total latency is 2 cycles.
- The CPU holds cpu_addr, cpu_wdata, cpu_size and cpu_write stable until cpu_ready. The block does not re-sample them in RMW_WR; mem_addr is derived from the held cpu_addr.
- cpu_read and cpu_write both high: the write has priority and the read is ignored (cpu_rdata=0).
- No request in IDLE: mem_read=0, mem_write=0, cpu_ready=0, cpu_rdata=0.
- Reset asserted in RMW_WR: the write is abandoned and memory is unchanged (memory reset re-initialises it anyway). The next state is IDLE.
- mem_write is never asserted outside word-store IDLE or RMW_WR.

Optional Feature:
- Macro: MEM_RMW_BRIDGE_ALIGN_CHECK_EN.
- Defined:
  - Misaligned accesses are: halfword with cpu_addr[0]=1, or word with cpu_addr[1:0]!=0.
  - Such an access suppresses mem_write, returns cpu_rdata=0 and asserts cpu_ready=1 for one cycle.
  - It sets fault=1 and enters FAULT.
  - FAULT stays until reset; every subsequent request gets cpu_ready=1 with no memory effect.
- Undefined:
  - Offending low address bits are silently masked (halfword uses cpu_addr[1], word ignores [1:0]).
  - fault is tied to 0 and FAULT is unreachable.

Test Plan:
- Word store 0x11223344 to 0x80 then word load 0x80 -> cpu_ready in 1 cycle each; cpu_rdata=0x11223344.
- Byte store 0xAB to 0x81 -> cpu_ready low in cycle 1, mem_write high only in cycle 2; subsequent word load 0x80 = 0x1122AB44.
- Halfword store 0xBEEF to 0x82, then halfword load 0x82 with cpu_unsigned=0 -> 0xFFFFBEEF; with cpu_unsigned=1 -> 0x0000BEEF; word at 0x80 = 0xBEEFAB44.
- Byte load 0x83 after writing 0x7F000000 to 0x80 -> signed 0x0000007F; then 0x80000000 -> signed 0xFFFFFF80, unsigned 0x00000080.
- Reset pulsed while in RMW_WR of a byte store -> mem_write deasserts immediately; state IDLE; fault=0.
- With MEM_RMW_BRIDGE_ALIGN_CHECK_EN defined, word store to 0x82 -> no mem_write, fault=1 sticky until reset. Without the macro -> store lands at 0x80.

Source files
------------

// File: rtl/mem_rmw_bridge.sv
// ---------------------------------------------------------------------------
// mem_rmw_bridge
//   Adapts a CPU byte/halfword/word access port to a word-only memory with a
//   combinational read and clocked write. Sub-word loads are lane-extracted
//   and sign/zero extended in the same cycle. Sub-word stores use a two-cycle
//   read-modify-write: read and merge in IDLE, write the merged word in RMW_WR.
//
//   Optional build macro: MEM_RMW_BRIDGE_ALIGN_CHECK_EN
//     defined   - misaligned halfword/word accesses are trapped into a sticky
//                 FAULT state (fault=1) and get no memory effect.
//     undefined - offending low address bits are masked, fault is tied to 0.
// ---------------------------------------------------------------------------
module mem_rmw_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_WR = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] merged_q;
    logic [DATA_W-1:0] merged_next;
    logic              capture;

    logic              is_byte;
    logic              is_half;
    logic              is_word;
    logic              misaligned;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [DATA_W-1:0] load_data;

    // Size decode: 11 is treated the same as a word access.
    assign is_byte = (cpu_size == 2'b00);
    assign is_half = (cpu_size == 2'b01);
    assign is_word = cpu_size[1];

    // Memory is always addressed by word; the held cpu_addr keeps it valid in RMW_WR.
    assign mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00};

`ifdef MEM_RMW_BRIDGE_ALIGN_CHECK_EN
    assign misaligned = (is_half && cpu_addr[0]) ||
                        (is_word && (cpu_addr[1:0] != 2'b00));
    assign fault      = (state_q == FAULT);
`else
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
`endif

    // Lane extraction for loads and lane replacement for the RMW merge word.
    always_comb begin
        // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
        load_byte   = mem_rdata[7:0];
        load_half   = cpu_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data   = mem_rdata;
        merged_next = mem_rdata;

        case (cpu_addr[1:0])
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase

        if (is_byte) begin
            load_data = cpu_unsigned ? {24'd0, load_byte}
                                     : {{24{load_byte[7]}}, load_byte};
            case (cpu_addr[1:0])
                2'd0:    merged_next[7:0]   = cpu_wdata[7:0];
                2'd1:    merged_next[15:8]  = cpu_wdata[7:0];
                2'd2:    merged_next[23:16] = cpu_wdata[7:0];
                default: merged_next[31:24] = cpu_wdata[7:0];
            endcase
        end else if (is_half) begin
            load_data = cpu_unsigned ? {16'd0, load_half}
                                     : {{16{load_half[15]}}, load_half};
            if (cpu_addr[1]) begin
                merged_next[31:16] = cpu_wdata[15:0];
            end else begin
                merged_next[15:0]  = cpu_wdata[15:0];
            end
        end
    end

    // Next-state and output decode for the access sequencer.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = cpu_wdata;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    // A store wins over a simultaneous load; cpu_rdata stays 0.
                    if (misaligned) begin
                        cpu_ready = 1'b1;
                        state_d   = FAULT;
                    end else if (is_word) begin
                        mem_write = 1'b1;
                        cpu_ready = 1'b1;
                    end else begin
                        mem_read  = 1'b1;
                        capture   = 1'b1;
                        state_d   = RMW_WR;
                    end
                end else if (cpu_read) begin
                    if (misaligned) begin
                        cpu_ready = 1'b1;
                        state_d   = FAULT;
                    end else begin
                        mem_read  = 1'b1;
                        cpu_ready = 1'b1;
                        cpu_rdata = load_data;
                    end
                end
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = merged_q;
                cpu_ready = 1'b1;
                state_d   = IDLE;
            end
            FAULT: begin
                // Trapped: acknowledge every request without touching memory.
                cpu_ready = cpu_read | cpu_write;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and merge buffer capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            // NOTE: the merge buffer is reset so mem_wdata never carries X after reset.
            merged_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            state_q <= state_d;
            if (capture) begin
                merged_q <= merged_next;
            end
        end
    end

endmodule
